// File: rtl/voice_gate_alloc.sv
// Polyphonic gate allocator: serial note-on/off commands mapped onto NVOICES
// envelope voices with retrigger, free-voice reuse and oldest-voice stealing.
module voice_gate_alloc #(
    parameter int NVOICES = 4,
    parameter int NOTE_W  = 7
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_on,
    input  logic [NOTE_W-1:0]           cmd_note,
    input  logic                        all_off,
    output logic [NVOICES-1:0]          GATE,
    output logic [NVOICES-1:0]          GATEchgd,
    output logic [NVOICES*NOTE_W-1:0]   voice_note,
    output logic [3:0]                  busy_cnt
);

    localparam int IW = $clog2(NVOICES);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic                r_on;
    logic [NOTE_W-1:0]   r_note;
    logic [NVOICES-1:0]  r_gate;
    logic [NVOICES-1:0]  r_chgd;
    logic [NOTE_W-1:0]   r_vnote [NVOICES];
    logic [IW-1:0]       r_rank  [NVOICES];
    logic [3:0]          r_busy;
    logic                r_mfound;
    logic [IW-1:0]       r_midx;
    logic                r_ffound;
    logic [IW-1:0]       r_fidx;
    logic [IW-1:0]       r_frank;
    logic [IW-1:0]       r_oidx;

    logic [IW-1:0]       w_tgt;
    logic                w_hit;
    logic [NVOICES-1:0]  w_gate_nxt;
    logic [NVOICES-1:0]  w_chgd_nxt;
    logic [3:0]          w_cnt;

    assign cmd_ready = (r_state == IDLE);
    assign GATE      = r_gate;
    assign GATEchgd  = r_chgd;
    assign busy_cnt  = r_busy;

    for (genvar g = 0; g < NVOICES; g++) begin : g_note
        assign voice_note[g*NOTE_W +: NOTE_W] = r_vnote[g];
    end

    // Note-off only touches a voice when a held match was found.
    always_comb begin
        w_tgt = r_oidx;
        if (r_mfound)
            w_tgt = r_midx;
        else if (r_on && r_ffound)
            w_tgt = r_fidx;
        w_hit = r_on | r_mfound;
    end

    always_comb begin
        w_gate_nxt = r_gate;
        w_chgd_nxt = '0;
        if (all_off) begin
            w_gate_nxt = '0;
            w_chgd_nxt = r_gate;
        end else if (r_state == COMMIT && w_hit) begin
            w_gate_nxt[w_tgt] = r_on;
            w_chgd_nxt[w_tgt] = 1'b1;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NVOICES; i++)
            w_cnt = w_cnt + 4'(w_gate_nxt[i]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_on     <= 1'b0;
            r_note   <= '0;
            r_gate   <= '0;
            r_chgd   <= '0;
            r_busy   <= '0;
            r_mfound <= 1'b0;
            r_midx   <= '0;
            r_ffound <= 1'b0;
            r_fidx   <= '0;
            r_frank  <= '0;
            r_oidx   <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                r_vnote[i] <= '0;
                r_rank[i]  <= IW'(NVOICES - 1 - i);
            end
        end else begin
            r_gate <= w_gate_nxt;
            r_chgd <= w_chgd_nxt;
            r_busy <= w_cnt;
            if (all_off) begin
                r_state <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (cmd_valid) begin
                            r_on     <= cmd_on;
                            r_note   <= cmd_note;
                            r_idx    <= '0;
                            r_mfound <= 1'b0;
                            r_ffound <= 1'b0;
                            r_state  <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (r_gate[r_idx] && r_vnote[r_idx] == r_note
                            && !r_mfound) begin
                            r_mfound <= 1'b1;
                            r_midx   <= r_idx;
                        end
                        if (!r_gate[r_idx]
                            && (!r_ffound || r_rank[r_idx] > r_frank)) begin
                            r_ffound <= 1'b1;
                            r_fidx   <= r_idx;
                            r_frank  <= r_rank[r_idx];
                        end
                        if (r_rank[r_idx] == IW'(NVOICES - 1))
                            r_oidx <= r_idx;
                        if (r_idx == IW'(NVOICES - 1))
                            r_state <= COMMIT;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                    COMMIT: begin
                        if (r_on) begin
                            r_vnote[w_tgt] <= r_note;
                            for (int j = 0; j < NVOICES; j++) begin
                                if (IW'(j) == w_tgt)
                                    r_rank[j] <= '0;
                                else if (r_rank[j] < r_rank[w_tgt])
                                    r_rank[j] <= r_rank[j] + 1'b1;
                            end
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
